// File: rtl/noc_route_pkg.sv
// Shared definitions for the switch route-reservation logic: direction
// encodings, an index-width helper and the per-output lock state.
package noc_route_pkg;

  localparam int DIR_NORTH = 0;
  localparam int DIR_SOUTH = 1;
  localparam int DIR_WEST  = 2;
  localparam int DIR_EAST  = 3;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// above the pointer, wrapping modulo N.
module rr_arbiter
  import noc_route_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(i_ptr) + k) % N;
      if (o_grant == '0 && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = PW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/route_allocator.sv
// Per-output route locks for an N x N switch: round-robin reservation,
// pulse relieve, crossbar select/busy drive and out-of-range request flag.
module route_allocator
  import noc_route_pkg::*;
#(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2,
  parameter int SEL_WIDTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               routeReserveRequestValid,
  input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [N-1:0]               routeRelieve,
  output logic [N-1:0]               routeReserveStatus,
  output logic [N*SEL_WIDTH-1:0]     outSel,
  output logic [N-1:0]               outBusy,
  output logic                       reqError
);

  localparam int PW = idx_width(N);

  lock_state_e          r_state [N];
  logic [SEL_WIDTH-1:0] r_owner [N];
  logic [PW-1:0]        r_ptr   [N];
  logic                 r_err;

  logic [N-1:0]  w_elig  [N];
  logic [N-1:0]  w_grant [N];
  logic [PW-1:0] w_idx   [N];
  logic [N-1:0]  w_status;
  logic          w_err;

  // Ownership is only ever derived from the lock table, so status and
  // select can never disagree.
  always_comb begin
    w_status = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (r_state[j] == LOCK_HELD && int'(r_owner[j]) == i) begin
          w_status[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_err = 1'b0;
    for (int j = 0; j < N; j++) begin
      w_elig[j] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_elig[j][i] = routeReserveRequestValid[i] && !w_status[i] && !routeRelieve[i] &&
                       (int'(routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]) == j);
      end
      if (routeReserveRequestValid[i] &&
          int'(routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]) >= N) begin
        w_err = 1'b1;
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_arb
    rr_arbiter #(.N(N), .PW(PW)) u_arb (
      .i_req   (w_elig[j]),
      .i_ptr   (r_ptr[j]),
      .o_grant (w_grant[j]),
      .o_idx   (w_idx[j])
    );
  end

  // A held output only frees on its owner's relieve; it cannot be re-granted
  // in that same cycle because arbitration sees the registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
      for (int j = 0; j < N; j++) begin
        r_state[j] <= LOCK_FREE;
        r_owner[j] <= '0;
        r_ptr[j]   <= '0;
      end
    end else begin
      r_err <= w_err;
      for (int j = 0; j < N; j++) begin
        if (r_state[j] == LOCK_HELD) begin
          if (routeRelieve[r_owner[j]]) begin
            r_state[j] <= LOCK_FREE;
            r_owner[j] <= '0;
          end
        end else if (|w_grant[j]) begin
          r_state[j] <= LOCK_HELD;
          r_owner[j] <= SEL_WIDTH'(w_idx[j]);
          if (int'(w_idx[j]) == N - 1) begin
            r_ptr[j] <= '0;
          end else begin
            r_ptr[j] <= w_idx[j] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    outBusy = '0;
    outSel  = '0;
    for (int j = 0; j < N; j++) begin
      outBusy[j]                           = (r_state[j] == LOCK_HELD);
      outSel[j*SEL_WIDTH +: SEL_WIDTH]     = r_owner[j];
    end
  end

  assign routeReserveStatus = w_status;
  assign reqError           = r_err;

endmodule

// File: tb/tb_route_allocator.sv
// Directed bench for route_allocator: a 4-port instance for the main flows and
// a 3-port instance for out-of-range requests, checked through a scoreboard.
module tb_route_allocator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] a_vld, a_rel, a_st, a_busy;
  logic [7:0] a_req, a_sel;
  logic       a_err;
  logic [2:0] b_vld, b_rel, b_st, b_busy;
  logic [5:0] b_req, b_sel;
  logic       b_err;

  route_allocator #(.N(4), .REQUEST_WIDTH(2), .SEL_WIDTH(2)) u_dut_a (
    .clk                      (clk),
    .rst                      (rst),
    .routeReserveRequestValid (a_vld),
    .routeReserveRequest      (a_req),
    .routeRelieve             (a_rel),
    .routeReserveStatus       (a_st),
    .outSel                   (a_sel),
    .outBusy                  (a_busy),
    .reqError                 (a_err)
  );

  route_allocator #(.N(3), .REQUEST_WIDTH(2), .SEL_WIDTH(2)) u_dut_b (
    .clk                      (clk),
    .rst                      (rst),
    .routeReserveRequestValid (b_vld),
    .routeReserveRequest      (b_req),
    .routeRelieve             (b_rel),
    .routeReserveStatus       (b_st),
    .outSel                   (b_sel),
    .outBusy                  (b_busy),
    .reqError                 (b_err)
  );

  typedef struct {
    int         cyc;
    bit         dut;
    string      name;
    logic [3:0] st;
    logic [3:0] busy;
    logic [7:0] sel;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compares every queued expectation whose cycle has arrived.
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.dut == 1'b0) begin
        chk({e.name, ".status"}, {4'h0, a_st},   {4'h0, e.st});
        chk({e.name, ".busy"},   {4'h0, a_busy}, {4'h0, e.busy});
        chk({e.name, ".sel"},    a_sel,          e.sel);
        chk({e.name, ".err"},    {7'h0, a_err},  {7'h0, e.err});
      end else begin
        chk({e.name, ".status"}, {5'h0, b_st},   {4'h0, e.st});
        chk({e.name, ".busy"},   {5'h0, b_busy}, {4'h0, e.busy});
        chk({e.name, ".sel"},    {2'h0, b_sel},  e.sel);
        chk({e.name, ".err"},    {7'h0, b_err},  {7'h0, e.err});
      end
    end
  end

  task automatic expa(input string nm, input logic [3:0] st, input logic [3:0] busy,
                      input logic [7:0] sel, input logic err);
    exp_t e;
    e.cyc = cyc + 1; e.dut = 1'b0; e.name = nm;
    e.st = st; e.busy = busy; e.sel = sel; e.err = err;
    q.push_back(e);
  endtask

  task automatic expb(input string nm, input logic [3:0] st, input logic [3:0] busy,
                      input logic [7:0] sel, input logic err);
    exp_t e;
    e.cyc = cyc + 1; e.dut = 1'b1; e.name = nm;
    e.st = st; e.busy = busy; e.sel = sel; e.err = err;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic areq(input int i, input int p);
    a_req[i*2 +: 2] = 2'(p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_vld = '0; a_rel = '0; a_req = '0;
    b_vld = '0; b_rel = '0; b_req = '0;
    step();
    expa("reset", 4'b0000, 4'b0000, 8'h00, 1'b0);
    expb("reset_b", 4'b0000, 4'b0000, 8'h00, 1'b0);
    step();
    rst = 1'b1;

    // Single request to east, then relieve.
    a_vld = 4'b0001; areq(0, 3);
    expa("single_grant", 4'b0001, 4'b1000, 8'h00, 1'b0); step();
    a_vld = 4'b0000;
    expa("single_hold", 4'b0001, 4'b1000, 8'h00, 1'b0); step();
    step(); step();
    a_rel = 4'b0001;
    expa("single_relieve", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    a_rel = 4'b0000;

    // Contention on output 0 between inputs 1 and 2.
    a_vld = 4'b0110; areq(1, 0); areq(2, 0);
    expa("cont_grant1", 4'b0010, 4'b0001, 8'h01, 1'b0); step();
    expa("cont_wait", 4'b0010, 4'b0001, 8'h01, 1'b0); step();
    a_rel = 4'b0010; a_vld = 4'b0100;
    expa("cont_rel1", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    a_rel = 4'b0000;
    expa("cont_grant2", 4'b0100, 4'b0001, 8'h02, 1'b0); step();
    a_vld = 4'b0000; a_rel = 4'b0100;
    expa("cont_rel2", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    a_rel = 4'b0000;
    a_vld = 4'b1001; areq(0, 0); areq(3, 0);
    expa("ptr_at_3", 4'b1000, 4'b0001, 8'h03, 1'b0); step();
    a_vld = 4'b0000; a_rel = 4'b1000;
    expa("ptr_rel", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    a_rel = 4'b0000;

    // All four outputs granted in parallel.
    a_vld = 4'b1111; a_req = 8'hB1;
    expa("parallel", 4'b1111, 4'b1111, 8'hB1, 1'b0); step();
    a_vld = 4'b0000;
    expa("parallel_hold", 4'b1111, 4'b1111, 8'hB1, 1'b0); step();

    // Reset while everything is locked; pointers must restart at 0.
    rst = 1'b0;
    expa("reset_midlock", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    rst = 1'b1;
    a_vld = 4'b1011; areq(0, 1); areq(1, 1); areq(3, 0);
    expa("post_reset", 4'b1001, 4'b0011, 8'h03, 1'b0); step();
    a_vld = 4'b0010; a_rel = 4'b1001;
    expa("rel_two", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    a_rel = 4'b0000;
    expa("waiter_grant", 4'b0010, 4'b0010, 8'h04, 1'b0); step();
    a_vld = 4'b0000; a_rel = 4'b0010;
    expa("waiter_rel", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    a_rel = 4'b0000;

    // Spurious relieve, second-route request, relieve with request.
    a_vld = 4'b0100; areq(2, 1);
    expa("own_out1", 4'b0100, 4'b0010, 8'h08, 1'b0); step();
    a_vld = 4'b0000; a_rel = 4'b1000;
    expa("spurious_rel", 4'b0100, 4'b0010, 8'h08, 1'b0); step();
    a_rel = 4'b0000;
    a_vld = 4'b0100; areq(2, 3);
    expa("second_route", 4'b0100, 4'b0010, 8'h08, 1'b0); step();
    expa("second_route2", 4'b0100, 4'b0010, 8'h08, 1'b0); step();
    a_rel = 4'b0100;
    expa("rel_and_req", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    a_rel = 4'b0000;
    expa("req_after_rel", 4'b0100, 4'b1000, 8'h80, 1'b0); step();
    a_vld = 4'b0000; a_rel = 4'b0100;
    expa("final_rel", 4'b0000, 4'b0000, 8'h00, 1'b0); step();
    a_rel = 4'b0000;

    // Three-port instance: request for nonexistent port 3.
    b_vld = 3'b001; b_req[1:0] = 2'd3;
    expb("oor", 4'b0000, 4'b0000, 8'h00, 1'b1); step();
    expb("oor_repeat", 4'b0000, 4'b0000, 8'h00, 1'b1); step();
    b_vld = 3'b010; b_req[3:2] = 2'd2;
    expb("oor_cleared", 4'b0010, 4'b0100, 8'h10, 1'b0); step();
    b_vld = 3'b000;
    expb("b_hold", 4'b0010, 4'b0100, 8'h10, 1'b0); step();

    step(); step();
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/route_allocator.md
Name: route_allocator

Overview:
- Switch-side responder to the per-port route-reservation protocol. Each input port's control logic requests an output port, receives a level grant, and later relieves the route with a pulse.
- Holds one lock per output port. Arbitrates contending inputs round-robin.
- Drives the crossbar select and busy flag for every output.
- Sits in the switch, between the N input port control units and the crossbar.

Parameters:
- N, 4, number of input ports and number of output ports; the switch is N x N.
- REQUEST_WIDTH, 2, width of one output-port request; must satisfy 2^REQUEST_WIDTH >= N.
- SEL_WIDTH, 2, width of one crossbar select field; must satisfy 2^SEL_WIDTH >= N.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset.
- routeReserveRequestValid  input  N  bit i: input i presents a request.
- routeReserveRequest  input  N*REQUEST_WIDTH  field i is the output port requested by input i (0 N, 1 S, 2 W, 3 E).
- routeRelieve  input  N  bit i: one-cycle pulse, input i releases its route.
- routeReserveStatus  output  N  bit i: input i currently owns an output (level).
- outSel  output  N*SEL_WIDTH  field j is the owning input index for output j.
- outBusy  output  N  bit j: output j is locked.
- reqError  output  1  one-cycle pulse: an out-of-range request was seen.

Behaviour:
- Reset (rst==0 at a clock edge):
  - All outputs FREE; outBusy=0, outSel=0, routeReserveStatus=0, reqError=0.
  - All round-robin pointers = 0.
  - This applies mid-operation and discards existing locks.
- Per-output state: FREE, or LOCKED(owner). The state is registered, and all outputs are registered.
- An input is eligible for output j in cycle t when all of the following hold:
  - routeReserveRequestValid[i]=1,
  - request field i = j,
  - routeReserveStatus[i]=0,
  - routeRelieve[i]=0.
- Arbitration: if output j is FREE in cycle t and it has eligible inputs, the edge ending cycle t grants output j to the first eligible input searching from pointer[j] upward, wrapping modulo N.
  - From cycle t+1: outBusy[j]=1, outSel[j]=winner, routeReserveStatus[winner]=1.
  - pointer[j] becomes (winner+1) mod N.
- Grant latency is 1 cycle. Requesters must hold valid and the request field stable until status rises. A losing request keeps waiting; it is not dropped.
- One route per input: a request from an input that already owns an output is ignored.
- Independent outputs grant in parallel in the same cycle.
- Relieve:
  - routeRelieve[i] in cycle t, with i owning output j → output j is FREE and routeReserveStatus[i]=0 from t+1.
  - A new grant on output j is visible at t+2 at the earliest.
  - A relieve from a non-owner is ignored, with no state change.
- Same-cycle relieve and request from the same input: relieve wins, and the request is first considered in cycle t+1.
- A relieve on output j does not make output j available to other requesters in the same cycle.
- Out-of-range request (field >= N with valid=1): no grant; reqError=1 for the next cycle. The pulse repeats while the request is held.
- routeReserveStatus[i] equals the OR over j of (outBusy[j] and outSel[j]==i). It must be derived consistently from the lock state, never set independently.

Decomposition:
- Shared package noc_route_pkg:
  - direction constants DIR_NORTH=0, DIR_SOUTH=1, DIR_WEST=2, DIR_EAST=3;
  - clog2-based width helper;
  - per-output lock-state typedef.
- Sub-module rr_arbiter, instantiated N times (one per output). Inputs: N-bit request vector and pointer. Outputs: one-hot grant and grant index. Purely combinational.
- Lock registers, pointers and relieve handling live in route_allocator.

Test Plan:
- Single request: cycle 1, input 0 valid with request 3 → cycle 2 routeReserveStatus=0001, outBusy=1000, outSel[3]=0; cycle 5 relieve[0] pulse → cycle 6 status=0000, outBusy=0000.
- Contention: inputs 1 and 2 both request output 0, pointer 0 → input 1 granted, pointer[0]=2.
  - Relieve[1] at cycle t → input 2 granted, status=0100 at t+2, pointer[0]=3.
- Parallel: inputs 0,1,2,3 request outputs 1,0,3,2 in the same cycle → next cycle status=1111, outBusy=1111, outSel=(1,0,3,2) for outputs 0..3.
- Spurious relieve: input 2 owns output 1; relieve[3] pulses → no change. Input 2 requests output 3 while owning output 1 → ignored, outBusy[3]=0.
- Out-of-range: N=3, REQUEST_WIDTH=2, input 0 requests 3 → no grant, reqError=1 the next cycle.
- Reset mid-lock: all four outputs locked, rst=0 for one cycle → next cycle all outputs zero, pointers 0. Then input 3 requests output 0 → granted 1 cycle after the request.
